flags_register_unit: RTL and testbench

- Holds the architectural status flags (zero, carry, negative, overflow) that feed the condition decoder in the execute stage.
- Captures ALU flag results when the executing instruction sets flags and its condition is satisfied.
- Supports explicit PSW writes.
- Saves/restores flags on interrupt entry/return through a small internal LIFO. Sits between the ALU outputs and the condition decoder inputs.

---
 rtl/flags_register_unit_pkg.sv | 23 ++
 rtl/flags_register_unit_if.sv | 48 ++++
 rtl/flags_register_unit_stack.sv | 69 ++++++
 rtl/flags_register_unit.sv | 98 +++++++++
 tb/tb_flags_register_unit.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/flags_register_unit_pkg.sv
// rtl/flags_register_unit_pkg.sv - flag bit positions, flag vector type and ALU packing helper
package flags_register_unit_pkg;

  localparam int FLAG_ZERO     = 0;
  localparam int FLAG_CARRY    = 1;
  localparam int FLAG_NEGATIVE = 2;
  localparam int FLAG_OVERFLOW = 3;
  localparam int FLAG_WIDTH    = 4;

  typedef logic [FLAG_WIDTH-1:0] flags_t;

  // Assemble the four ALU result bits into architectural flag order.
  function automatic flags_t pack_alu(input logic z, input logic c, input logic n, input logic v);
    flags_t f;
    f                = '0;
    f[FLAG_ZERO]     = z;
    f[FLAG_CARRY]    = c;
    f[FLAG_NEGATIVE] = n;
    f[FLAG_OVERFLOW] = v;
    return f;
  endfunction

endpackage

// File: rtl/flags_register_unit_if.sv
// rtl/flags_register_unit_if.sv - execute-stage flag update bus between pipeline and flags register unit
interface flags_register_unit_if
  import flags_register_unit_pkg::*;
#(
  parameter int STACK_DEPTH = 4
) ();

  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

  logic               updateEnable;
  logic               setFlags;
  logic               conditionSatisfied;
  logic               aluZero;
  logic               aluCarry;
  logic               aluNegative;
  logic               aluOverflow;
  logic               writeEnable;
  flags_t             writeData;
  logic               pushRequest;
  logic               popRequest;
  logic               clearError;

  logic               zero;
  logic               carry;
  logic               negative;
  logic               overflow;
  logic [DEPTH_W-1:0] stackDepth;
  logic               stackFull;
  logic               stackEmpty;
  logic               stackError;

  modport master (
    output updateEnable, setFlags, conditionSatisfied,
    output aluZero, aluCarry, aluNegative, aluOverflow,
    output writeEnable, writeData, pushRequest, popRequest, clearError,
    input  zero, carry, negative, overflow,
    input  stackDepth, stackFull, stackEmpty, stackError
  );

  modport slave (
    input  updateEnable, setFlags, conditionSatisfied,
    input  aluZero, aluCarry, aluNegative, aluOverflow,
    input  writeEnable, writeData, pushRequest, popRequest, clearError,
    output zero, carry, negative, overflow,
    output stackDepth, stackFull, stackEmpty, stackError
  );

endinterface

// File: rtl/flags_register_unit_stack.sv
// rtl/flags_register_unit_stack.sv - LIFO of flag snapshots for nested interrupt save/restore
module flags_register_unit_stack
  import flags_register_unit_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int DEPTH_W = $clog2(DEPTH + 1)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               push_i,
  input  logic               pop_i,
  input  flags_t             data_i,
  output flags_t             top_o,
  output logic [DEPTH_W-1:0] depth_o,
  output logic               full_o,
  output logic               empty_o,
  output logic               overflow_o,
  output logic               underflow_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  flags_t             mem_q [DEPTH];
  logic [DEPTH_W-1:0] depth_q;
  logic [DEPTH_W-1:0] depth_d;
  logic               do_push;
  logic               do_pop;
  logic [AW-1:0]      wr_idx;
  logic [AW-1:0]      top_idx;

  assign full_o      = (depth_q == DEPTH_W'(DEPTH));
  assign empty_o     = (depth_q == '0);
  // A simultaneous push and pop is a conflict: neither side acts.
  assign do_push     = push_i & ~pop_i & ~full_o;
  assign do_pop      = pop_i & ~push_i & ~empty_o;
  assign overflow_o  = push_i & ~pop_i & full_o;
  assign underflow_o = pop_i & ~push_i & empty_o;

  assign wr_idx  = AW'(depth_q);
  assign top_idx = AW'(depth_q - DEPTH_W'(1));
  assign top_o   = empty_o ? '0 : mem_q[top_idx];
  assign depth_o = depth_q;

  // Depth moves by one per accepted push/pop; guards above keep it from wrapping.
  always_comb begin
    depth_d = depth_q;
    if (do_push) begin
      depth_d = depth_q + DEPTH_W'(1);
    end else if (do_pop) begin
      depth_d = depth_q - DEPTH_W'(1);
    end
  end

  // Snapshot storage and occupancy; popped slots are left stale.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      depth_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      depth_q <= depth_d;
      if (do_push) begin
        mem_q[wr_idx] <= data_i;
      end
    end
  end

endmodule

// File: rtl/flags_register_unit.sv
// rtl/flags_register_unit.sv - architectural status flags with ALU capture, PSW write and interrupt save/restore
module flags_register_unit
  import flags_register_unit_pkg::*;
#(
  parameter int STACK_DEPTH = 4
) (
  input logic                  clock,
  input logic                  reset,
  flags_register_unit_if.slave bus
);

  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

  flags_t             flags_q;
  flags_t             flags_d;
  flags_t             merged;
  flags_t             alu_flags;
  flags_t             stack_top;
  logic               alu_capture;
  logic               pop_valid;
  logic               err_q;
  logic               err_d;
  logic               new_error;
  logic               stk_full;
  logic               stk_empty;
  logic               stk_overflow;
  logic               stk_underflow;
  logic [DEPTH_W-1:0] stk_depth;

  assign alu_capture = bus.updateEnable & bus.setFlags & bus.conditionSatisfied;
  assign alu_flags   = pack_alu(bus.aluZero, bus.aluCarry, bus.aluNegative, bus.aluOverflow);
  assign pop_valid   = bus.popRequest & ~bus.pushRequest & ~stk_empty;

  // The merged value is what a push saves, so a same-cycle write or ALU update is never lost.
  always_comb begin
    merged = flags_q;
    if (bus.writeEnable) begin
      merged = bus.writeData;
    end else if (alu_capture) begin
      merged = alu_flags;
    end
  end

  // A valid restore overrides any same-cycle write or ALU capture.
  always_comb begin
    flags_d = pop_valid ? stack_top : merged;
  end

  assign new_error = stk_overflow | stk_underflow | (bus.pushRequest & bus.popRequest);

  // Sticky error: a fresh error this cycle beats a clear request.
  always_comb begin
    err_d = err_q;
    if (new_error) begin
      err_d = 1'b1;
    end else if (bus.clearError) begin
      err_d = 1'b0;
    end
  end

  flags_register_unit_stack #(
    .DEPTH   (STACK_DEPTH),
    .DEPTH_W (DEPTH_W)
  ) u_stack (
    .clk_i       (clock),
    .rst_ni      (reset),
    .push_i      (bus.pushRequest),
    .pop_i       (bus.popRequest),
    .data_i      (merged),
    .top_o       (stack_top),
    .depth_o     (stk_depth),
    .full_o      (stk_full),
    .empty_o     (stk_empty),
    .overflow_o  (stk_overflow),
    .underflow_o (stk_underflow)
  );

  // Live flag register and sticky error bit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      flags_q <= '0;
      err_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      err_q   <= err_d;
    end
  end

  assign bus.zero       = flags_q[FLAG_ZERO];
  assign bus.carry      = flags_q[FLAG_CARRY];
  assign bus.negative   = flags_q[FLAG_NEGATIVE];
  assign bus.overflow   = flags_q[FLAG_OVERFLOW];
  assign bus.stackDepth = stk_depth;
  assign bus.stackFull  = stk_full;
  assign bus.stackEmpty = stk_empty;
  assign bus.stackError = err_q;

endmodule

// File: tb/tb_flags_register_unit.sv
// tb/tb_flags_register_unit.sv - randomized and directed checks of flags_register_unit against a queue model
module tb_flags_register_unit;

  localparam int D = 4;

  logic clock;
  logic reset;
  int   vectors;
  int   miscompares;
  logic check_en;

  logic [3:0] m_flags;
  logic [3:0] m_stk[$];
  logic       m_err;

  flags_register_unit_if #(.STACK_DEPTH(D)) bus ();

  flags_register_unit #(.STACK_DEPTH(D)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [3:0] dut_flags();
    return {bus.overflow, bus.negative, bus.carry, bus.zero};
  endfunction

  always @(negedge clock) begin
    if (check_en) begin
      vectors++;
      if (dut_flags() !== m_flags || bus.stackDepth !== 3'(m_stk.size()) ||
          bus.stackFull !== (m_stk.size() == D) || bus.stackEmpty !== (m_stk.size() == 0) ||
          bus.stackError !== m_err) begin
        miscompares++;
        $display("FAIL cycle t=%0t: got flags=%b depth=%0d full=%b empty=%b err=%b expected flags=%b depth=%0d full=%b empty=%b err=%b",
                 $time, dut_flags(), bus.stackDepth, bus.stackFull, bus.stackEmpty, bus.stackError,
                 m_flags, m_stk.size(), m_stk.size() == D, m_stk.size() == 0, m_err);
      end
    end
  end

  task automatic drive_idle();
    bus.updateEnable = 0; bus.setFlags = 0; bus.conditionSatisfied = 0;
    bus.aluZero = 0; bus.aluCarry = 0; bus.aluNegative = 0; bus.aluOverflow = 0;
    bus.writeEnable = 0; bus.writeData = '0;
    bus.pushRequest = 0; bus.popRequest = 0; bus.clearError = 0;
  endtask

  // One clock cycle: drive inputs, predict next state, advance past the edge, commit prediction.
  task automatic cyc(input logic we, input logic [3:0] wd, input logic ue, input logic sf, input logic cs,
                     input logic [3:0] alu, input logic psh, input logic pp, input logic clr);
    logic [3:0] merged;
    logic [3:0] nf;
    logic [3:0] nstk[$];
    logic       nerr;
    logic       fresh;
    bus.writeEnable = we; bus.writeData = wd;
    bus.updateEnable = ue; bus.setFlags = sf; bus.conditionSatisfied = cs;
    bus.aluZero = alu[0]; bus.aluCarry = alu[1]; bus.aluNegative = alu[2]; bus.aluOverflow = alu[3];
    bus.pushRequest = psh; bus.popRequest = pp; bus.clearError = clr;

    merged = we ? wd : (ue && sf && cs) ? alu : m_flags;
    nstk   = m_stk;
    nf     = merged;
    fresh  = 1'b0;
    if (psh && pp) begin
      fresh = 1'b1;
    end else if (psh) begin
      if (nstk.size() < D) nstk.push_back(merged);
      else fresh = 1'b1;
    end else if (pp) begin
      if (nstk.size() > 0) nf = nstk.pop_back();
      else fresh = 1'b1;
    end
    nerr = fresh ? 1'b1 : (clr ? 1'b0 : m_err);

    @(posedge clock);
    #1;
    m_flags = nf;
    m_stk   = nstk;
    m_err   = nerr;
  endtask

  task automatic mid_reset();
    check_en = 0;
    #2;
    reset = 0;
    #1;
    chk("async_reset_flags", dut_flags(), 4'b0000);
    chk("async_reset_depth", bus.stackDepth, 0);
    chk("async_reset_empty", bus.stackEmpty, 1);
    chk("async_reset_full", bus.stackFull, 0);
    chk("async_reset_err", bus.stackError, 0);
    m_flags = '0;
    m_stk.delete();
    m_err = 0;
    drive_idle();
    @(negedge clock);
    #1;
    reset = 1;
    check_en = 1;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    check_en = 0;
    m_flags = '0;
    m_err = 0;
    reset = 0;
    drive_idle();
    #12;
    chk("reset_flags", dut_flags(), 4'b0000);
    chk("reset_depth", bus.stackDepth, 0);
    chk("reset_empty", bus.stackEmpty, 1);
    chk("reset_full", bus.stackFull, 0);
    chk("reset_err", bus.stackError, 0);
    reset = 1;
    check_en = 1;

    // Condition not satisfied, then satisfied
    cyc(0, 4'h0, 1, 1, 0, 4'b1111, 0, 0, 0);
    chk("cond_fail_hold", dut_flags(), 4'b0000);
    cyc(0, 4'h0, 1, 1, 1, 4'b1111, 0, 0, 0);
    chk("cond_pass_capture", dut_flags(), 4'b1111);

    // Push with same-cycle ALU capture, then overwrite, then restore
    cyc(1, 4'b0001, 0, 0, 0, 4'h0, 0, 0, 0);
    chk("psw_write", dut_flags(), 4'b0001);
    cyc(0, 4'h0, 1, 1, 1, 4'b0100, 1, 0, 0);
    chk("push_merge_live", dut_flags(), 4'b0100);
    chk("push_merge_depth", bus.stackDepth, 1);
    cyc(1, 4'b1000, 0, 0, 0, 4'h0, 0, 0, 0);
    chk("write_after_push", dut_flags(), 4'b1000);
    cyc(0, 4'h0, 0, 0, 0, 4'h0, 0, 1, 0);
    chk("pop_restore", dut_flags(), 4'b0100);
    chk("pop_depth", bus.stackDepth, 0);
    chk("pop_no_err", bus.stackError, 0);

    // Overflow on fifth push, clear, reverse-order restore
    for (int i = 1; i <= 5; i++) cyc(1, 4'(i), 0, 0, 0, 4'h0, 1, 0, 0);
    chk("full_depth", bus.stackDepth, 4);
    chk("full_flag", bus.stackFull, 1);
    chk("overflow_err", bus.stackError, 1);
    chk("overflow_live", dut_flags(), 4'd5);
    cyc(0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 1);
    chk("clear_err", bus.stackError, 0);
    for (int i = 4; i >= 1; i--) begin
      cyc(0, 4'h0, 0, 0, 0, 4'h0, 0, 1, 0);
      chk("lifo_order", dut_flags(), 4'(i));
    end
    chk("drained_empty", bus.stackEmpty, 1);

    // Underflow with a same-cycle PSW write
    cyc(1, 4'b0110, 0, 0, 0, 4'h0, 0, 1, 0);
    chk("underflow_flags", dut_flags(), 4'b0110);
    chk("underflow_depth", bus.stackDepth, 0);
    chk("underflow_err", bus.stackError, 1);

    // Push+pop conflict at depth 1 with ALU capture
    cyc(0, 4'h0, 0, 0, 0, 4'h0, 1, 0, 1);
    chk("push_with_clear", bus.stackError, 0);
    cyc(0, 4'h0, 1, 1, 1, 4'b0010, 1, 1, 0);
    chk("conflict_depth", bus.stackDepth, 1);
    chk("conflict_flags", dut_flags(), 4'b0010);
    chk("conflict_err", bus.stackError, 1);

    // Error wins over clear in the same cycle
    cyc(0, 4'h0, 0, 0, 0, 4'h0, 1, 1, 1);
    chk("err_beats_clear", bus.stackError, 1);

    // Reach flags 1011 with depth 2, then reset between edges
    cyc(1, 4'b1011, 0, 0, 0, 4'h0, 1, 0, 0);
    chk("pre_reset_flags", dut_flags(), 4'b1011);
    chk("pre_reset_depth", bus.stackDepth, 2);
    mid_reset();

    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 7) == 0), 4'($urandom), $urandom_range(0, 1), $urandom_range(0, 1),
          $urandom_range(0, 1), 4'($urandom), ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
          ($urandom_range(0, 7) == 0));
      if (i == 1500) mid_reset();
    end

    check_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
